if_stage: RTL and testbench

- Instruction-fetch stage of the RV32I core: owns the PC, issues word fetches to instruction memory and buffers one fetched instruction.
- Hands the instruction to decode through a valid/ready handshake.
- id_imm_src carries inst[31:7], the 25-bit immediate source consumed directly by the downstream immediate sign-extender.
- Single outstanding request; redirects from execute kill in-flight fetches.

---
 rtl/if_stage.sv | 126 ++++++++++++
 tb/tb_if_stage.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues one word fetch at a time and buffers one instruction for decode.
// Latency: gnt in cycle N, rvalid in N+1 -> id_valid in N+2; best case one instruction every 3 cycles.
// Backpressure: id_valid holds id_inst/id_pc until id_ready; no new fetch is issued while the buffer is full.
// Ports: clk/rst_n; imem_req/addr/gnt/rvalid/rdata memory side; redirect_valid/pc from execute;
//        id_valid/ready/inst/pc/imm_src to decode; misalign flag.
// Optional: define IF_MISALIGN_CHK_EN to trap misaligned redirect targets in an ERR state
//           (otherwise the low two target bits are dropped and misalign stays 0).
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [24:0] id_imm_src,
    output logic        misalign
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    // S_ERR is only ever entered when the misalign check is compiled in.
    typedef enum logic [2:0] {
        S_REQ   = 3'd0,
        S_WAIT  = 3'd1,
        S_DRAIN = 3'd2,
        S_HOLD  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] fetch_pc;
    logic [31:0] target_pc;
    logic        redirect_bad;

`ifdef IF_MISALIGN_CHK_EN
    assign target_pc    = redirect_pc;
    assign redirect_bad = (redirect_pc[1:0] != 2'b00);
`else
    assign target_pc    = {redirect_pc[31:2], 2'b00};
    assign redirect_bad = 1'b0;
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = &{1'b0, redirect_pc[1:0]};
`endif

    // A request is never raised in a redirect cycle, so a grant can only
    // ever be taken for the PC that is actually current.
    assign imem_req   = rst_n && (state == S_REQ) && !redirect_valid;
    assign imem_addr  = pc;
    assign id_imm_src = id_inst[31:7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_REQ;
            pc       <= RESET_PC;
            fetch_pc <= RESET_PC;
            id_valid <= 1'b0;
            id_inst  <= NOP;
            id_pc    <= 32'h0000_0000;
            misalign <= 1'b0;
        end else if (redirect_valid) begin
            // Redirect wins over everything; any buffered instruction is
            // flushed (if decode took it this cycle, that already counted).
            id_valid <= 1'b0;
            misalign <= redirect_bad;
            if (!redirect_bad) begin
                pc <= target_pc;
            end
            // A response still in flight must be swallowed before fetching
            // again; if it arrives right now it is simply dropped.
            if ((state == S_WAIT || state == S_DRAIN) && !imem_rvalid) begin
                state <= S_DRAIN;
            end else if (redirect_bad) begin
                state <= S_ERR;
            end else begin
                state <= S_REQ;
            end
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_gnt) begin
                        fetch_pc <= pc;
                        pc       <= pc + 32'd4;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        id_inst  <= imem_rdata;
                        id_pc    <= fetch_pc;
                        id_valid <= 1'b1;
                        state    <= S_HOLD;
                    end
                end
                S_DRAIN: begin
                    // misalign remembers a bad redirect seen while draining.
                    if (imem_rvalid) begin
                        state <= misalign ? S_ERR : S_REQ;
                    end
                end
                S_HOLD: begin
                    if (id_ready) begin
                        id_valid <= 1'b0;
                        state    <= S_REQ;
                    end
                end
                S_ERR: begin
                    state <= S_ERR;
                end
                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [24:0] id_imm_src;
    logic        misalign;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_inst        (id_inst),
        .id_pc          (id_pc),
        .id_imm_src     (id_imm_src),
        .misalign       (misalign)
    );

    int checks = 0;
    int errors = 0;

    // Transaction-level reference: next PC, one outstanding fetch (maybe
    // marked for discard), a one-entry decode buffer and an error flag.
    logic [31:0] m_pc, m_fetch_pc, m_buf_inst, m_buf_pc;
    bit          m_out, m_drop, m_buf_vld, m_err;

    // Bench memory: one pending response with a random delay.
    bit mem_pend;
    int mem_lat;

    task automatic model_reset();
        m_pc = 32'h0; m_fetch_pc = 32'h0; m_buf_inst = 32'h13; m_buf_pc = 32'h0;
        m_out = 0; m_drop = 0; m_buf_vld = 0; m_err = 0;
    endtask

    function automatic bit m_req();
        return rst_n && !redirect_valid && !m_out && !m_buf_vld && !m_err;
    endfunction

    task automatic drive(input bit rv, input logic [31:0] rpc, input bit g,
                         input bit rvl, input logic [31:0] rd, input bit rdy);
        redirect_valid = rv; redirect_pc = rpc; imem_gnt = g;
        imem_rvalid = rvl; imem_rdata = rd; id_ready = rdy;
    endtask

    // Advance one clock and apply the cycle's inputs to the reference.
    task automatic tick();
        bit req;
        req = m_req();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (redirect_valid) begin
            m_buf_vld = 0;
            if (m_out && !imem_rvalid) m_drop = 1;
            else begin m_out = 0; m_drop = 0; end
`ifdef IF_MISALIGN_CHK_EN
            if (redirect_pc % 4 != 0) m_err = 1;
            else begin m_err = 0; m_pc = redirect_pc; end
`else
            m_pc = redirect_pc - (redirect_pc % 4);
`endif
        end else if (req && imem_gnt) begin
            m_out = 1; m_drop = 0; m_fetch_pc = m_pc; m_pc = m_pc + 32'd4;
        end else if (m_out && imem_rvalid) begin
            if (!m_drop) begin
                m_buf_vld = 1; m_buf_inst = imem_rdata; m_buf_pc = m_fetch_pc;
            end
            m_out = 0; m_drop = 0;
        end else if (m_buf_vld && id_ready) begin
            m_buf_vld = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 32'h0, 1, 1, 32'hFFFF_FFFF, 1);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", id_valid); end
        checks++; if (id_inst !== 32'h0000_0013 || id_pc !== 32'h0) begin errors++; $display("FAIL reset_buf: inst=%h pc=%h want 00000013/00000000", id_inst, id_pc); end
        checks++; if (misalign !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL reset_misc: misalign=%b addr=%h want 0/00000000", misalign, imem_addr); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(0, 32'h0, 0, 0, 32'h0, 0);
    endtask

    task automatic test_basic();
        logic [31:0] inst;
        inst = 32'h0050_0093;
        for (int k = 0; k < 3; k++) begin
            drive(0, 32'h0, 1, 0, 32'h0, 1); @(negedge clk);
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin errors++; $display("FAIL basic_req k=%0d: req=%b addr=%h want 1/%h", k, imem_req, imem_addr, 4 * k); end
            tick();
            drive(0, 32'h0, 1, 1, inst, 1); @(negedge clk);
            checks++; if (imem_req !== 1'b0 || id_valid !== 1'b0) begin errors++; $display("FAIL basic_wait k=%0d: req=%b valid=%b want 0/0", k, imem_req, id_valid); end
            tick();
            drive(0, 32'h0, 1, 0, 32'h0, 1); @(negedge clk);
            checks++; if (id_valid !== 1'b1 || id_pc !== 32'(4 * k) || id_inst !== inst) begin errors++; $display("FAIL basic_deliver k=%0d: valid=%b pc=%h inst=%h want 1/%h/%h", k, id_valid, id_pc, id_inst, 4 * k, inst); end
            checks++; if (id_imm_src !== 25'(inst >> 7)) begin errors++; $display("FAIL basic_imm k=%0d: got %h want %h", k, id_imm_src, 25'(inst >> 7)); end
            tick();
        end
    endtask

    task automatic test_stall();
        logic [31:0] inst;
        inst = $urandom;
        drive(0, 32'h0, 1, 0, 32'h0, 1); @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin errors++; $display("FAIL stall_req: req=%b addr=%h want 1/0000000c", imem_req, imem_addr); end
        tick();
        drive(0, 32'h0, 0, 1, inst, 0); @(negedge clk); tick();
        for (int i = 0; i < 5; i++) begin
            drive(0, 32'h0, 1, 0, $urandom, 0); @(negedge clk);
            checks++; if (id_valid !== 1'b1 || id_inst !== inst || id_pc !== 32'hC || imem_req !== 1'b0) begin errors++; $display("FAIL stall_hold i=%0d: valid=%b inst=%h pc=%h req=%b want 1/%h/0000000c/0", i, id_valid, id_inst, id_pc, imem_req, inst); end
            tick();
        end
        drive(0, 32'h0, 1, 0, 32'h0, 1); @(negedge clk);
        checks++; if (id_valid !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL stall_accept: valid=%b req=%b want 1/0", id_valid, imem_req); end
        tick();
        drive(0, 32'h0, 0, 0, 32'h0, 1); @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10 || id_valid !== 1'b0) begin errors++; $display("FAIL stall_next: req=%b addr=%h valid=%b want 1/00000010/0", imem_req, imem_addr, id_valid); end
        tick();
    endtask

    task automatic test_redirect_wait();
        logic [31:0] inst;
        inst = $urandom;
        drive(0, 32'h0, 1, 0, 32'h0, 1); @(negedge clk); tick();
        drive(1, 32'h100, 1, 0, 32'h0, 1); @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rdw_redirect_req: got %b want 0", imem_req); end
        tick();
        drive(0, 32'h0, 1, 1, 32'hDEAD_BEEF, 1); @(negedge clk);
        checks++; if (imem_req !== 1'b0 || id_valid !== 1'b0) begin errors++; $display("FAIL rdw_drain: req=%b valid=%b want 0/0", imem_req, id_valid); end
        tick();
        drive(0, 32'h0, 1, 0, 32'h0, 1); @(negedge clk);
        checks++; if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL rdw_refetch: valid=%b req=%b addr=%h want 0/1/00000100", id_valid, imem_req, imem_addr); end
        tick();
        drive(0, 32'h0, 0, 1, inst, 1); @(negedge clk); tick();
        drive(0, 32'h0, 0, 0, 32'h0, 1); @(negedge clk);
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_inst !== inst) begin errors++; $display("FAIL rdw_deliver: valid=%b pc=%h inst=%h want 1/00000100/%h", id_valid, id_pc, id_inst, inst); end
        tick();
    endtask

    task automatic test_redirect_rvalid();
        drive(0, 32'h0, 1, 0, 32'h0, 1); @(negedge clk); tick();
        drive(1, 32'h200, 0, 1, 32'hDEAD_BEEF, 1); @(negedge clk); tick();
        for (int i = 0; i < 2; i++) begin
            drive(0, 32'h0, 0, 0, 32'h0, 1); @(negedge clk);
            checks++; if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL rdr_after i=%0d: valid=%b req=%b addr=%h want 0/1/00000200", i, id_valid, imem_req, imem_addr); end
            tick();
        end
    endtask

    task automatic test_wrap();
        drive(1, 32'hFFFF_FFFC, 1, 0, 32'h0, 1); @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL wrap_redirect_req: got %b want 0", imem_req); end
        tick();
        drive(0, 32'h0, 1, 0, 32'h0, 1); @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_first: req=%b addr=%h want 1/fffffffc", imem_req, imem_addr); end
        tick();
        drive(0, 32'h0, 0, 1, 32'h0000_0013, 1); @(negedge clk); tick();
        drive(0, 32'h0, 0, 0, 32'h0, 1); @(negedge clk);
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc: valid=%b pc=%h want 1/fffffffc", id_valid, id_pc); end
        tick();
        drive(0, 32'h0, 0, 0, 32'h0, 1); @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_second: req=%b addr=%h want 1/00000000", imem_req, imem_addr); end
        tick();
    endtask

    task automatic test_misalign();
        drive(1, 32'h102, 0, 0, 32'h0, 1); @(negedge clk); tick();
`ifdef IF_MISALIGN_CHK_EN
        for (int i = 0; i < 3; i++) begin
            drive(0, 32'h0, 1, 0, 32'h0, 1); @(negedge clk);
            checks++; if (misalign !== 1'b1 || imem_req !== 1'b0 || id_valid !== 1'b0) begin errors++; $display("FAIL mis_err i=%0d: misalign=%b req=%b valid=%b want 1/0/0", i, misalign, imem_req, id_valid); end
            tick();
        end
        drive(1, 32'h200, 1, 0, 32'h0, 1); @(negedge clk); tick();
        drive(0, 32'h0, 0, 0, 32'h0, 1); @(negedge clk);
        checks++; if (misalign !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL mis_clear: misalign=%b req=%b addr=%h want 0/1/00000200", misalign, imem_req, imem_addr); end
        tick();
`else
        drive(0, 32'h0, 0, 0, 32'h0, 1); @(negedge clk);
        checks++; if (misalign !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL mis_forced: misalign=%b req=%b addr=%h want 0/1/00000100", misalign, imem_req, imem_addr); end
        tick();
`endif
    endtask

    task automatic test_random();
        mem_pend = 0; mem_lat = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            bit rv, g, rvl, rdy, exp_req;
            logic [31:0] rpc, rd;
            rv  = ($urandom_range(0, 11) == 0);
            rpc = $urandom;
            if ($urandom_range(0, 7) == 0) rpc = rpc | 32'hFFFF_FFF0;
            if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
            g   = ($urandom_range(0, 2) != 0);
            rvl = 0;
            if (mem_pend) begin
                if (mem_lat == 0) rvl = 1;
                else mem_lat--;
            end else begin
                rvl = ($urandom_range(0, 19) == 0);
            end
            rd  = $urandom;
            rdy = ($urandom_range(0, 9) < 7);
            drive(rv, rpc, g, rvl, rd, rdy);
            exp_req = m_req();
            if (rvl) mem_pend = 0;
            if (exp_req && g) begin mem_pend = 1; mem_lat = $urandom_range(0, 2); end
            @(negedge clk);
            checks++; if (imem_req !== exp_req) begin errors++; $display("FAIL rnd_req cyc=%0d: got %b want %b", cyc, imem_req, exp_req); end
            if (exp_req) begin
                checks++; if (imem_addr !== m_pc) begin errors++; $display("FAIL rnd_addr cyc=%0d: got %h want %h", cyc, imem_addr, m_pc); end
            end
            checks++; if (id_valid !== m_buf_vld) begin errors++; $display("FAIL rnd_valid cyc=%0d: got %b want %b", cyc, id_valid, m_buf_vld); end
            if (m_buf_vld) begin
                checks++; if (id_inst !== m_buf_inst || id_pc !== m_buf_pc || id_imm_src !== 25'(m_buf_inst >> 7)) begin errors++; $display("FAIL rnd_buf cyc=%0d: inst=%h pc=%h imm=%h want %h/%h/%h", cyc, id_inst, id_pc, id_imm_src, m_buf_inst, m_buf_pc, 25'(m_buf_inst >> 7)); end
            end
            checks++; if (misalign !== m_err) begin errors++; $display("FAIL rnd_misalign cyc=%0d: got %b want %b", cyc, misalign, m_err); end
            tick();
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] inst;
        inst = $urandom;
        // The rvalid closes out any fetch left pending by the random phase.
        drive(1, 32'h40, 0, 1, 32'h0, 0); @(negedge clk); tick();
        drive(0, 32'h0, 1, 0, 32'h0, 0); @(negedge clk); tick();
        drive(0, 32'h0, 0, 1, inst, 0); @(negedge clk); tick();
        drive(0, 32'h0, 0, 0, 32'h0, 0); @(negedge clk);
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h40 || id_inst !== inst) begin errors++; $display("FAIL arst_pre: valid=%b pc=%h inst=%h want 1/00000040/%h", id_valid, id_pc, id_inst, inst); end
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checks++; if (id_valid !== 1'b0 || imem_req !== 1'b0 || id_inst !== 32'h0000_0013 || id_pc !== 32'h0 || imem_addr !== 32'h0) begin errors++; $display("FAIL arst_now: valid=%b req=%b inst=%h pc=%h addr=%h want 0/0/00000013/00000000/00000000", id_valid, imem_req, id_inst, id_pc, imem_addr); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_redirect_wait();
        test_redirect_rvalid();
        test_wrap();
        test_misalign();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
